adc_scan_master: RTL



---
 rtl/adc_scan_master.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_master.sv
// Round-robin SPI (mode 0) scan master for an MCP320x-class ADC.
// Averages 2^AVG_LOG2 conversions per enabled channel into a readable result file.
module adc_scan_master #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned CMD_W    = 5,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned AVG_LOG2 = 2,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [CH_W-1:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              sample_valid,
    output logic [CH_W-1:0]   sample_ch,
    output logic [DATA_W-1:0] sample_data,
    output logic              busy,
    output logic              adc_sck,
    output logic              adc_sce,
    output logic              adc_sout,
    input  logic              adc_sin
);

    localparam int unsigned FRAME_BITS = CMD_W + 1 + DATA_W;
    localparam int unsigned HALF_CNT   = 2 * FRAME_BITS;
    localparam int unsigned HCNT_W     = $clog2(HALF_CNT);
    localparam int unsigned DIV_W      = $clog2(CLK_DIV);
    localparam int unsigned ACC_W      = DATA_W + AVG_LOG2;
    localparam int unsigned CONV_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned ADDR_W     = CMD_W - 2;

    if (NUM_CH < 1 || NUM_CH > (1 << ADDR_W)) begin : g_bad_num_ch
        $error("NUM_CH does not fit the ADC channel address field");
    end
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("CLK_DIV must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, SELECT, SHIFT, DESELECT} state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [CH_W-1:0]     ptr_q, ptr_d, ch_q, ch_d, found_ch, sel_ch;
    logic [CONV_W-1:0]   conv_q, conv_d;
    logic [ACC_W-1:0]    acc_q, acc_d, sum;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [CMD_W-1:0]    tx_q, tx_d, cmd;
    logic                sck_q, sck_d, sce_q, sce_d, sout_q, sout_d, busy_q, busy_d;
    logic                sv_q, sv_d;
    logic [CH_W-1:0]     sch_q, sch_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic [DATA_W-1:0]   result_q [NUM_CH];
    logic [DATA_W-1:0]   result_d [NUM_CH];
    logic                tick, state_chg, go_select, first_desel, last_conv;
    int unsigned         idx;

    assign tick        = (cnt_q == DIV_W'(CLK_DIV - 1));
    assign state_chg   = (state_d != state_q);
    assign go_select   = state_chg && (state_d == SELECT);
    assign first_desel = (state_q == DESELECT) && (cnt_q == '0) && (hcnt_q == '0);
    assign last_conv   = (conv_q == CONV_W'((1 << AVG_LOG2) - 1));
    assign sum         = acc_q + ACC_W'(rx_q);
    assign sel_ch      = (conv_q == '0) ? found_ch : ch_q;
    assign cmd         = {2'b11, ADDR_W'(sel_ch)};

    // First set mask bit at or after the pointer, wrapping; lowest offset wins.
    always_comb begin
        found_ch = ptr_q;
        idx      = 0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            idx = 32'(ptr_q) + 32'(i);
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (|(ch_mask & (NUM_CH'(1) << idx))) found_ch = CH_W'(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (enable && |ch_mask) state_d = SELECT;
            SELECT:   if (tick) state_d = SHIFT;
            SHIFT:    if (tick && hcnt_q == HCNT_W'(HALF_CNT - 1)) state_d = DESELECT;
            DESELECT: if (tick && hcnt_q == HCNT_W'(1))
                          state_d = (enable && |ch_mask) ? SELECT : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = (state_chg || tick) ? '0 : cnt_q + DIV_W'(1);
        hcnt_d   = (state_chg || state_q == IDLE) ? '0 :
                   (tick ? hcnt_q + HCNT_W'(1) : hcnt_q);
        ptr_d    = ptr_q;
        ch_d     = ch_q;
        conv_d   = conv_q;
        acc_d    = acc_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        sck_d    = sck_q;
        sce_d    = sce_q;
        sout_d   = sout_q;
        sv_d     = 1'b0;
        sch_d    = sch_q;
        sdata_d  = sdata_q;
        result_d = result_q;
        busy_d   = (state_d != IDLE);

        // Sample MISO on the edge that raises sck; advance MOSI on the falling edge.
        if (state_q == SHIFT && tick) begin
            sck_d = ~sck_q;
            if (!sck_q) begin
                rx_d = {rx_q[DATA_W-2:0], adc_sin};
            end else begin
                sout_d = tx_q[CMD_W-1];
                tx_d   = {tx_q[CMD_W-2:0], 1'b0};
            end
        end

        if (first_desel) begin
            if (last_conv) begin
                result_d[ch_q] = DATA_W'(sum >> AVG_LOG2);
                sv_d    = 1'b1;
                sch_d   = ch_q;
                sdata_d = DATA_W'(sum >> AVG_LOG2);
                acc_d   = '0;
                conv_d  = '0;
                ptr_d   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
            end else begin
                acc_d  = sum;
                conv_d = conv_q + CONV_W'(1);
            end
        end

        if (go_select) begin
            ch_d   = sel_ch;
            sce_d  = 1'b0;
            sck_d  = 1'b0;
            sout_d = cmd[CMD_W-1];
            tx_d   = {cmd[CMD_W-2:0], 1'b0};
            rx_d   = '0;
        end

        if (state_chg && state_d == DESELECT) begin
            sce_d  = 1'b1;
            sck_d  = 1'b0;
            sout_d = 1'b0;
        end

        // Leaving the scan abandons any partial group; the pointer stays put.
        if (state_chg && state_d == IDLE) begin
            acc_d  = '0;
            conv_d = '0;
            sce_d  = 1'b1;
            sck_d  = 1'b0;
            sout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            hcnt_q  <= '0;
            ptr_q   <= '0;
            ch_q    <= '0;
            conv_q  <= '0;
            acc_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            sck_q   <= 1'b0;
            sce_q   <= 1'b1;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            sv_q    <= 1'b0;
            sch_q   <= '0;
            sdata_q <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) result_q[i] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            ptr_q    <= ptr_d;
            ch_q     <= ch_d;
            conv_q   <= conv_d;
            acc_q    <= acc_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            sck_q    <= sck_d;
            sce_q    <= sce_d;
            sout_q   <= sout_d;
            busy_q   <= busy_d;
            sv_q     <= sv_d;
            sch_q    <= sch_d;
            sdata_q  <= sdata_d;
            result_q <= result_d;
        end
    end

    assign rd_data      = (32'(rd_addr) < NUM_CH) ? result_q[rd_addr] : '0;
    assign sample_valid = sv_q;
    assign sample_ch    = sch_q;
    assign sample_data  = sdata_q;
    assign busy         = busy_q;
    assign adc_sck      = sck_q;
    assign adc_sce      = sce_q;
    assign adc_sout     = sout_q;

endmodule
